// File: rtl/bp_cfg_link_pkg.sv
// Shared definitions for the per-core config bus link.
// Holds the bus field widths, the config register address map, the cache
// mode encodings and the command/response record layouts used by the
// host-side loader and by each tile's bp_cfg_responder.
package bp_cfg_link_pkg;

  localparam int cfg_core_width_lp = 8;
  localparam int cfg_addr_width_lp = 16;
  localparam int cfg_data_width_lp = 64;

  // Config register address map
  typedef enum logic [cfg_addr_width_lp-1:0] {
    e_cfg_freeze      = 16'h0000,
    e_cfg_core_id     = 16'h0001,
    e_cfg_icache_mode = 16'h0002,
    e_cfg_dcache_mode = 16'h0003,
    e_cfg_cce_mode    = 16'h0004,
    e_cfg_scratch     = 16'h0005
  } bp_cfg_reg_e;

  // Cache mode encodings carried in the icache/dcache mode registers
  typedef enum logic [1:0] {
    e_normal   = 2'd0,
    e_uncached = 2'd1,
    e_nonspec  = 2'd2
  } bp_cache_mode_e;

  typedef struct packed {
    logic                         w;
    logic [cfg_core_width_lp-1:0] core;
    logic [cfg_addr_width_lp-1:0] addr;
    logic [cfg_data_width_lp-1:0] data;
  } bp_cfg_cmd_s;

  typedef struct packed {
    logic                         w;
    logic                         err;
    logic [cfg_data_width_lp-1:0] data;
  } bp_cfg_resp_s;

endpackage

// File: rtl/bp_cfg_responder.sv
// Per-core config bus endpoint.
// Decodes {core, addr, w, data} commands from the host config loader, owns
// this core's config registers (freeze, icache/dcache mode, cce mode,
// scratch) and returns a read-data or write-ack response on a valid/ready
// channel. Broadcast writes (core id all-ones) are applied silently; reads
// and writes for other cores are consumed without effect.
//
// Ports:
//   clk_i, reset_i       clock, asynchronous active-high reset
//   my_core_i            this tile's core id (static after reset)
//   cfg_v_i/cfg_ready_o  command handshake
//   cfg_w_i, cfg_core_i, cfg_addr_i, cfg_data_i   command fields
//   resp_v_o/resp_ready_i  response handshake
//   resp_w_o, resp_err_o, resp_data_o            response fields
//   freeze_o, icache_mode_o, dcache_mode_o, cce_mode_o  register outputs
module bp_cfg_responder
  import bp_cfg_link_pkg::*;
#(
  parameter int cfg_core_width_p = cfg_core_width_lp,
  parameter int cfg_addr_width_p = cfg_addr_width_lp,
  parameter int cfg_data_width_p = cfg_data_width_lp
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [cfg_core_width_p-1:0] my_core_i,

  input  logic                        cfg_v_i,
  output logic                        cfg_ready_o,
  input  logic                        cfg_w_i,
  input  logic [cfg_core_width_p-1:0] cfg_core_i,
  input  logic [cfg_addr_width_p-1:0] cfg_addr_i,
  input  logic [cfg_data_width_p-1:0] cfg_data_i,

  output logic                        resp_v_o,
  input  logic                        resp_ready_i,
  output logic                        resp_w_o,
  output logic                        resp_err_o,
  output logic [cfg_data_width_p-1:0] resp_data_o,

  output logic                        freeze_o,
  output logic [1:0]                  icache_mode_o,
  output logic [1:0]                  dcache_mode_o,
  output logic                        cce_mode_o
);

  typedef enum logic [0:0] {
    e_ready = 1'b0,
    e_resp  = 1'b1
  } state_e;

  state_e                      state_r;
  logic                        freeze_r;
  logic [1:0]                  icache_mode_r;
  logic [1:0]                  dcache_mode_r;
  logic                        cce_mode_r;
  logic [63:0]                 scratch_r;

  logic                        resp_v_r;
  logic                        resp_w_r;
  logic                        resp_err_r;
  logic [cfg_data_width_p-1:0] resp_data_r;

  logic                        accept_s;
  logic                        bcast_s;
  logic                        match_s;
  logic                        addr_ok_s;
  logic                        writable_s;
  logic                        wr_en_s;
  logic                        resp_load_s;
  logic [cfg_data_width_p-1:0] rd_data_s;

  // Ready is a straight decode of the state flop, independent of resp_ready_i
  assign cfg_ready_o = (state_r == e_ready);
  assign accept_s    = cfg_v_i & cfg_ready_o;

  // Broadcast takes precedence so an all-ones local id never produces a response
  assign bcast_s     = &cfg_core_i;
  assign match_s     = (cfg_core_i == my_core_i) & ~bcast_s;

  assign wr_en_s     = accept_s & cfg_w_i & (match_s | bcast_s) & writable_s;
  assign resp_load_s = accept_s & match_s;

  // Address decode: read data (zero-extended), mapped and writable flags
  always_comb begin
    rd_data_s  = '0;
    addr_ok_s  = 1'b0;
    writable_s = 1'b0;
    case (cfg_addr_i)
      e_cfg_freeze: begin
        rd_data_s[0] = freeze_r;
        addr_ok_s    = 1'b1;
        writable_s   = 1'b1;
      end
      e_cfg_core_id: begin
        rd_data_s  = {{(cfg_data_width_p-cfg_core_width_p){1'b0}}, my_core_i};
        addr_ok_s  = 1'b1;
        writable_s = 1'b0;
      end
      e_cfg_icache_mode: begin
        rd_data_s[1:0] = icache_mode_r;
        addr_ok_s      = 1'b1;
        writable_s     = 1'b1;
      end
      e_cfg_dcache_mode: begin
        rd_data_s[1:0] = dcache_mode_r;
        addr_ok_s      = 1'b1;
        writable_s     = 1'b1;
      end
      e_cfg_cce_mode: begin
        rd_data_s[0] = cce_mode_r;
        addr_ok_s    = 1'b1;
        writable_s   = 1'b1;
      end
      e_cfg_scratch: begin
        rd_data_s  = scratch_r;
        addr_ok_s  = 1'b1;
        writable_s = 1'b1;
      end
      default: begin
        rd_data_s  = '0;
        addr_ok_s  = 1'b0;
        writable_s = 1'b0;
      end
    endcase
  end

  // Config register file; writes keep only the low bits of the data word
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      freeze_r      <= 1'b1;
      icache_mode_r <= 2'b00;
      dcache_mode_r <= 2'b00;
      cce_mode_r    <= 1'b0;
      scratch_r     <= 64'h0;
    end else if (wr_en_s) begin
      case (cfg_addr_i)
        e_cfg_freeze:      freeze_r      <= cfg_data_i[0];
        e_cfg_icache_mode: icache_mode_r <= cfg_data_i[1:0];
        e_cfg_dcache_mode: dcache_mode_r <= cfg_data_i[1:0];
        e_cfg_cce_mode:    cce_mode_r    <= cfg_data_i[0];
        e_cfg_scratch:     scratch_r     <= cfg_data_i[63:0];
        default: begin
          freeze_r      <= freeze_r;
          icache_mode_r <= icache_mode_r;
          dcache_mode_r <= dcache_mode_r;
          cce_mode_r    <= cce_mode_r;
          scratch_r     <= scratch_r;
        end
      endcase
    end
  end

  // Response FSM; read data is captured at the accept edge and held until taken
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= e_ready;
      resp_v_r    <= 1'b0;
      resp_w_r    <= 1'b0;
      resp_err_r  <= 1'b0;
      resp_data_r <= '0;
    end else begin
      case (state_r)
        e_ready: begin
          if (resp_load_s) begin
            state_r     <= e_resp;
            resp_v_r    <= 1'b1;
            resp_w_r    <= cfg_w_i;
            resp_err_r  <= cfg_w_i ? ~writable_s : ~addr_ok_s;
            resp_data_r <= (cfg_w_i | ~addr_ok_s) ? '0 : rd_data_s;
          end
        end
        e_resp: begin
          if (resp_ready_i) begin
            state_r     <= e_ready;
            resp_v_r    <= 1'b0;
            resp_w_r    <= 1'b0;
            resp_err_r  <= 1'b0;
            resp_data_r <= '0;
          end
        end
        default: begin
          state_r  <= e_ready;
          resp_v_r <= 1'b0;
        end
      endcase
    end
  end

  assign resp_v_o      = resp_v_r;
  assign resp_w_o      = resp_w_r;
  assign resp_err_o    = resp_err_r;
  assign resp_data_o   = resp_data_r;

  assign freeze_o      = freeze_r;
  assign icache_mode_o = icache_mode_r;
  assign dcache_mode_o = dcache_mode_r;
  assign cce_mode_o    = cce_mode_r;

endmodule
